bitty_sequencer: RTL
====================

// Module: bitty_sequencer
// PURPOSE
//  Program sequencer for the bitty core. Fetches 16-bit instructions from a synchronous
//  instruction ROM and issues them one at a time to bitty (d_instr/run), waiting for done
//  before advancing. Counts retired instructions and flags a hung core via a watchdog.
//  Sits between the instruction ROM and bitty at the top level.
// PARAMETERS
//  ADDR_W       8     ROM address width; PC wraps modulo 2**ADDR_W
//  TIMEOUT_CYC  64    max cycles in WAIT before a timeout error (>=2)
// PORTS
//  clk          in   1         single clock, rising edge
//  reset        in   1         asynchronous, active-high reset
//  start        in   1         pulse: begin executing at start_pc (ignored unless IDLE/ERR)
//  stop         in   1         request graceful halt after current instruction retires
//  start_pc     in   ADDR_W    first instruction address, sampled with start
//  prog_len     in   ADDR_W+1  instructions to execute, sampled with start
//  mem_addr     out  ADDR_W    ROM read address (registered PC)
//  mem_rdata    in   16        ROM data, valid 1 cycle after mem_addr
//  cpu_instr    out  16        instruction to bitty d_instr, held stable FETCH->WAIT end
//  cpu_run      out  1         one-cycle issue strobe to bitty run
//  cpu_done     in   1         bitty done; sampled only in WAIT
//  busy         out  1         high in FETCH/ISSUE/WAIT/NEXT
//  finished     out  1         one-cycle pulse when program or stop completes
//  timeout_err  out  1         sticky watchdog error, cleared by start or reset
//  instr_count  out  16        retired instructions since last start, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state=IDLE; mem_addr, cpu_instr, instr_count = 0; cpu_run, busy, finished,
//   timeout_err = 0; remaining-count, watchdog, stop_pending cleared. All regs async reset.
//  States: IDLE, FETCH, ISSUE, WAIT, NEXT, ERR. All outputs registered.
//  IDLE: start & prog_len!=0 -> FETCH; pc<=start_pc, remaining<=prog_len, instr_count<=0,
//   timeout_err<=0, stop_pending<=0. start & prog_len==0 -> stay IDLE, finished=1 next cycle,
//   instr_count<=0. No start -> stay.
//  FETCH (1 cycle): mem_addr=pc; capture mem_rdata into cpu_instr at exit -> ISSUE.
//  ISSUE (1 cycle): cpu_run=1; watchdog<=0 -> WAIT. cpu_done ignored here.
//  WAIT: cpu_done=1 -> NEXT, instr_count++ (saturating). Else watchdog++; watchdog reaching
//   TIMEOUT_CYC-1 without done -> ERR, timeout_err<=1. done and timeout same cycle: done wins.
//  NEXT (1 cycle): remaining--, pc<=pc+1 (wraps). If remaining==1 or stop_pending -> IDLE with
//   finished=1 next cycle; else -> FETCH.
//  ERR: busy=0, cpu_run=0; stays until start (same handling as IDLE start) or reset.
//  Latency: start at edge t -> FETCH t+1 -> cpu_run high during t+2 -> WAIT from t+3.
//   Per instruction: 3 cycles overhead + bitty execution cycles until done.
//  stop: may arrive in any busy state; sets stop_pending; current instruction always retires.
//   stop in IDLE/ERR ignored. stop and start same cycle in IDLE: start wins, stop ignored.
//  start while busy: ignored (no restart, sampled values unchanged).
//  cpu_instr never changes between ISSUE and WAIT exit; cpu_run never high outside ISSUE.
//  Reset mid-instruction: immediate return to IDLE, outputs to reset values; bitty is reset on
//   the same reset net.
// TESTING
//  1. ROM[0..2]=16'h1111,2222,3333; start_pc=0,prog_len=3, done 2 cycles after each run ->
//     three cpu_run pulses carrying 1111,2222,3333 in order; finished pulse; instr_count=3.
//  2. start_pc=8'hFE, prog_len=3 -> mem_addr sequence FE,FF,00; instr_count=3.
//  3. prog_len=0 -> no cpu_run, finished pulse exactly 1 cycle after start, busy stays 0.
//  4. Hold cpu_done=0 after issue, TIMEOUT_CYC=64 -> ERR and timeout_err=1 after 64 WAIT
//     cycles; new start clears timeout_err and executes normally.
//  5. prog_len=10, assert stop during 2nd instruction's WAIT -> 2 retired, finished pulse,
//     no 3rd cpu_run; start pulse during busy shows no effect.
//  6. Assert reset while in WAIT -> all outputs 0 asynchronously, state IDLE; start then
//     restarts from new start_pc with instr_count counting from 0.

Source files
------------

// File: rtl/bitty_sequencer.sv
// Program sequencer: fetches 16-bit instructions from ROM, issues them to bitty
// one at a time, counts retirements and watches for a hung core.
// Ports: clk/reset, start/stop/start_pc/prog_len control, mem_addr/mem_rdata ROM,
//        cpu_instr/cpu_run/cpu_done core handshake, busy/finished/timeout_err/instr_count status.
module bitty_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [ADDR_W:0]   prog_len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       cpu_instr,
  output logic              cpu_run,
  input  logic              cpu_done,
  output logic              busy,
  output logic              finished,
  output logic              timeout_err,
  output logic [15:0]       instr_count
);

  localparam int WD_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, WAIT, NEXT, ERR
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W:0]   rem, rem_n;
  logic [WD_W-1:0]   wd, wd_n;
  logic              stop_pending, stopp_n;
  logic [ADDR_W-1:0] pc_n;
  logic [15:0]       instr_n, cnt_n;
  logic              tout_n, fin_n, run_n, busy_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = mem_addr;
    rem_n   = rem;
    wd_n    = wd;
    cnt_n   = instr_count;
    instr_n = cpu_instr;
    tout_n  = timeout_err;
    stopp_n = stop_pending;
    fin_n   = 1'b0;
    unique case (state)
      IDLE, ERR: begin
        if (start) begin
          cnt_n  = '0;
          tout_n = 1'b0;
          if (prog_len != '0) begin
            state_n = FETCH;
            pc_n    = start_pc;
            rem_n   = prog_len;
            stopp_n = 1'b0;
          end else begin
            state_n = IDLE;
            fin_n   = 1'b1;
          end
        end
      end
      FETCH: begin
        stopp_n = stop_pending | stop;
        instr_n = mem_rdata;
        state_n = ISSUE;
      end
      ISSUE: begin
        stopp_n = stop_pending | stop;
        wd_n    = '0;
        state_n = WAIT;
      end
      WAIT: begin
        stopp_n = stop_pending | stop;
        if (cpu_done) begin
          state_n = NEXT;
          if (instr_count != 16'hFFFF) begin
            cnt_n = instr_count + 16'd1;
          end
        end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
          state_n = ERR;
          tout_n  = 1'b1;
        end else begin
          wd_n = wd + WD_W'(1);
        end
      end
      NEXT: begin
        rem_n = rem - (ADDR_W+1)'(1);
        pc_n  = mem_addr + ADDR_W'(1);
        // a stop landing in this very cycle still halts before the next fetch
        if (rem == (ADDR_W+1)'(1) || stop_pending || stop) begin
          state_n = IDLE;
          fin_n   = 1'b1;
        end else begin
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
    run_n  = (state_n == ISSUE);
    busy_n = (state_n == FETCH) || (state_n == ISSUE) ||
             (state_n == WAIT)  || (state_n == NEXT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr     <= '0;
      rem          <= '0;
      wd           <= '0;
      stop_pending <= 1'b0;
      cpu_instr    <= '0;
      instr_count  <= '0;
      timeout_err  <= 1'b0;
      finished     <= 1'b0;
      cpu_run      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      mem_addr     <= pc_n;
      rem          <= rem_n;
      wd           <= wd_n;
      stop_pending <= stopp_n;
      cpu_instr    <= instr_n;
      instr_count  <= cnt_n;
      timeout_err  <= tout_n;
      finished     <= fin_n;
      cpu_run      <= run_n;
      busy         <= busy_n;
    end
  end

endmodule
